// File: rtl/renew_dispatch_scheduler_if.sv
// Request channel into the renew dispatch scheduler: valid/ready handshake
// carrying the payload, the register operands and the barrier flag.
interface renew_dispatch_scheduler_if #(
  parameter int INSTR_WIDTH   = 32,
  parameter int REG_CTN_WIDTH = 5
);
  logic                     req_valid;
  logic                     req_ready;
  logic [INSTR_WIDTH-1:0]   req_instr;
  logic [REG_CTN_WIDTH-1:0] req_rd;
  logic [REG_CTN_WIDTH-1:0] req_rs1;
  logic [REG_CTN_WIDTH-1:0] req_rs2;
  logic                     req_sync;

  modport master (
    output req_valid, req_instr, req_rd, req_rs1, req_rs2, req_sync,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_instr, req_rd, req_rs1, req_rs2, req_sync,
    output req_ready
  );
endinterface

// File: rtl/renew_dispatch_scheduler.sv
// Buffers work requests, checks register hazards, and issues each one to an
// eligible processor; barrier entries hold issue until both sides are idle.
module renew_dispatch_scheduler #(
  parameter int REGISTER_AMOUNT = 32,
  parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT),
  parameter int INSTR_WIDTH     = 32,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  renew_dispatch_scheduler_if.slave     req,
  input  logic [REGISTER_AMOUNT-1:0]    processing_register_table,
  input  logic                          processor_idle_1,
  input  logic                          processor_idle_2,
  input  logic                          synchronized_processors,
  output logic                          boot_renew_register_1,
  output logic                          boot_renew_register_2,
  output logic [REG_CTN_WIDTH-1:0]      register_num,
  output logic [INSTR_WIDTH-1:0]        dispatch_instr,
  output logic                          barrier_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {EMPTY, ISSUE, BARRIER} state_t;

  typedef struct packed {
    logic                     sync;
    logic [REG_CTN_WIDTH-1:0] rs2;
    logic [REG_CTN_WIDTH-1:0] rs1;
    logic [REG_CTN_WIDTH-1:0] rd;
    logic [INSTR_WIDTH-1:0]   instr;
  } entry_t;

  entry_t                     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]           count_reg, count_next;
  state_t                     state_reg;
  logic                       rr_ptr_reg;
  logic                       launched_1_reg, launched_2_reg;
  logic [REGISTER_AMOUNT-1:0] shadow_reg;
  logic                       boot_1_reg, boot_2_reg;
  logic [REG_CTN_WIDTH-1:0]   register_num_reg;
  logic [INSTR_WIDTH-1:0]     dispatch_instr_reg;

  entry_t                     head;
  logic [REGISTER_AMOUNT-1:0] busy_mask;
  logic [REG_CTN_WIDTH-1:0]   src_idx [3];
  logic [2:0]                 src_hazard;
  logic                       hazard, eligible_1, eligible_2;
  logic                       push, pop, in_issue, issue_ok, issue_to_1, issue_to_2;
  logic                       barrier_release;

  assign req.req_ready = (count_reg < DEPTH_C);
  assign push          = req.req_valid && req.req_ready;

  // Combinational head read: the hazard check must see the entry before it pops.
  assign head      = fifo_mem[rd_ptr_reg];
  assign busy_mask = processing_register_table | shadow_reg;

  assign src_idx[0] = head.rd;
  assign src_idx[1] = head.rs1;
  assign src_idx[2] = head.rs2;

  for (genvar gi = 0; gi < 3; gi++) begin : g_src_hazard
    assign src_hazard[gi] = (src_idx[gi] != '0) && busy_mask[src_idx[gi]];
  end

  assign hazard     = |src_hazard;
  assign eligible_1 = processor_idle_1 && !launched_1_reg;
  assign eligible_2 = processor_idle_2 && !launched_2_reg;

  assign in_issue   = (state_reg == ISSUE) && (count_reg != '0);
  assign issue_ok   = in_issue && !head.sync && !hazard && (eligible_1 || eligible_2);
  // rr_ptr_reg = 0 favours processor 1 when both are free
  assign issue_to_1 = issue_ok && eligible_1 && (!eligible_2 || !rr_ptr_reg);
  assign issue_to_2 = issue_ok && !issue_to_1;

  assign barrier_release = (state_reg == BARRIER) && processor_idle_1 && processor_idle_2 &&
                           !launched_1_reg && !launched_2_reg && synchronized_processors;
  assign pop = issue_ok || barrier_release;

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + CNT_W'(1);
    else if (!push && pop)
      count_next = count_reg - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= '{sync: req.req_sync, rs2: req.req_rs2, rs1: req.req_rs1,
                                 rd: req.req_rd, instr: req.req_instr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      count_reg          <= '0;
      state_reg          <= EMPTY;
      rr_ptr_reg         <= 1'b0;
      launched_1_reg     <= 1'b0;
      launched_2_reg     <= 1'b0;
      shadow_reg         <= '0;
      boot_1_reg         <= 1'b0;
      boot_2_reg         <= 1'b0;
      register_num_reg   <= '0;
      dispatch_instr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;

      if (issue_ok && eligible_1 && eligible_2)
        rr_ptr_reg <= ~rr_ptr_reg;

      // An issue can only target an idle processor, so set and clear never collide.
      if (issue_to_1)             launched_1_reg <= 1'b1;
      else if (!processor_idle_1) launched_1_reg <= 1'b0;
      if (issue_to_2)             launched_2_reg <= 1'b1;
      else if (!processor_idle_2) launched_2_reg <= 1'b0;

      shadow_reg <= '0;
      if (issue_ok) shadow_reg[head.rd] <= 1'b1;

      boot_1_reg         <= issue_to_1;
      boot_2_reg         <= issue_to_2;
      register_num_reg   <= issue_ok ? head.rd    : '0;
      dispatch_instr_reg <= issue_ok ? head.instr : '0;

      case (state_reg)
        EMPTY: begin
          if (count_reg != '0) state_reg <= ISSUE;
        end
        ISSUE: begin
          if (count_reg == '0)
            state_reg <= EMPTY;
          else if (head.sync)
            state_reg <= BARRIER;
          else if (issue_ok && count_next == '0)
            state_reg <= EMPTY;
        end
        BARRIER: begin
          if (barrier_release)
            state_reg <= (count_next == '0) ? EMPTY : ISSUE;
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end

  assign boot_renew_register_1 = boot_1_reg;
  assign boot_renew_register_2 = boot_2_reg;
  assign register_num          = register_num_reg;
  assign dispatch_instr        = dispatch_instr_reg;
  assign barrier_busy          = (state_reg == BARRIER);
  assign fifo_count            = count_reg;
endmodule

// File: doc/renew_dispatch_scheduler.md
Name: renew_dispatch_scheduler

Overview:
- Sits in front of the dual-processor register management block.
- Buffers incoming work requests, checks register hazards against the processing register table, and picks processor 1 or 2 for each request.
- Produces the one-cycle boot_renew_register_1/2 pulses and the shared register_num.
- Also sequences synchronization barriers: issue stops until both processors are idle and synchronized.

Parameters:
- REGISTER_AMOUNT, 32, number of architectural registers.
- REG_CTN_WIDTH, $clog2(REGISTER_AMOUNT), register index width.
- INSTR_WIDTH, 32, payload width forwarded to the chosen processor.
- FIFO_DEPTH, 4, pending-request buffer entries (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  buffer can accept this cycle.
- req_instr  in  INSTR_WIDTH  payload.
- req_rd  in  REG_CTN_WIDTH  destination register.
- req_rs1  in  REG_CTN_WIDTH  source register 1.
- req_rs2  in  REG_CTN_WIDTH  source register 2.
- req_sync  in  1  request is a barrier (rd/rs ignored).
- processing_register_table  in  REGISTER_AMOUNT  bit i = register i in flight.
- processor_idle_1  in  1  processor 1 idle.
- processor_idle_2  in  1  processor 2 idle.
- synchronized_processors  in  1  both processors synchronized.
- boot_renew_register_1  out  1  issue pulse to processor 1.
- boot_renew_register_2  out  1  issue pulse to processor 2.
- register_num  out  REG_CTN_WIDTH  rd of the issued entry.
- dispatch_instr  out  INSTR_WIDTH  payload of the issued entry.
- barrier_busy  out  1  barrier in progress.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.

Behaviour:
Reset:
- FIFO is flushed, state=EMPTY, rr_ptr=processor 1, launched_1/2=0, shadow mask=0.
- All outputs are 0 except req_ready=1.
- Reset asserted mid-operation discards all queued requests and any barrier in progress. A boot pulse on that cycle is suppressed.

FIFO:
- Push when req_valid&&req_ready.
- req_ready = (fifo_count<FIFO_DEPTH). There is no pass-through when full, even if a pop occurs in the same cycle.
- Push and pop in the same cycle leave the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Hazard check on the head entry:
- hazard = table/shadow bit set for rd, rs1 or rs2.
- Register 0 never causes a hazard.
- Shadow mask: bit rd is set on issue and cleared the next cycle. This covers the one-cycle lag before the table reflects the issue.

Eligibility:
- Processor x is eligible when processor_idle_x && !launched_x.
- launched_x is set on an issue to x and cleared on the first cycle processor_idle_x is low.
- Contract: a processor drops idle within 2 cycles of its boot pulse.

State machine:
- EMPTY:
  - Stays in EMPTY while fifo_count==0.
  - Moves to ISSUE when an entry is present.
- ISSUE:
  - If the head has req_sync=1, go to BARRIER (no pop yet).
  - Else, if there is no hazard and at least one processor is eligible, issue the head:
    - Only one issue per cycle.
    - If only one processor is eligible, issue to it.
    - If both are eligible, issue to rr_ptr's processor, then toggle rr_ptr.
  - Issue asserts boot_renew_register_x=1 for exactly one cycle (registered), with register_num=rd and dispatch_instr=payload on the same cycle.
  - The entry pops on issue. The head stalls otherwise.
  - Go to EMPTY if the FIFO becomes empty.
- BARRIER:
  - barrier_busy=1. Nothing is issued.
  - When both processors are idle, both launched flags=0, and synchronized_processors=1: pop the barrier, then go to ISSUE, or EMPTY if the FIFO is now empty.

Output values:
- Outputs are registered. Latency from push into an empty FIFO to the boot pulse is 2 cycles minimum.
- register_num and dispatch_instr are 0 on non-issue cycles.
- boot_renew_register_1 and boot_renew_register_2 are never high together.

Test Plan:
- Reset, then push rd=5, rs1=2, rs2=3 with both processors idle and table=0 -> boot_renew_register_1 pulses 1 cycle at push+2, register_num=5, fifo_count returns to 0.
- Push two independent requests (rd=4, then rd=6), both processors idle -> first issues to processor 1 and second to processor 2 on consecutive issue cycles. No simultaneous pulses.
- Table bit 7 set; push rs1=7 -> head stalls, req_ready stays 1 until the FIFO is full. Clear bit 7 -> issue on the next cycle.
- Back-to-back rd=9 then rs2=9 -> second request is held by the shadow mask for 1 cycle, then by the table bit. It issues only after the table clears.
- Push a barrier with processor 2 busy -> barrier_busy=1, no issues. Drive idle_2=1 and synchronized_processors=1 -> barrier pops, and a queued request issues the following cycle.
- Fill 4 entries with both processors busy -> req_ready=0, fifo_count=4. Assert rst for 1 cycle -> fifo_count=0, all pulses 0, req_ready=1.
